// File: rtl/dshade_iter_if.sv
// Port bundle for the Gouraud intensity/Z iterator: GPU register writes,
// step request/ack from the data-control stage, and the output phrase.
interface dshade_iter_if;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [31:0] gpu_din;
    logic        gourd;
    logic        gourz;
    logic [2:0]  daddmode;
    logic        out_ready;
    logic        step_ack;
    logic        out_valid;
    logic [31:0] pix_i;
    logic [63:0] pix_z;

    // Valid/ready: a phrase transfers on any rising edge where out_valid and
    // out_ready are both high; out_valid never drops without a transfer.
    modport master (
        output reg_wr, reg_addr, gpu_din, gourd, gourz, daddmode, out_ready,
        input  step_ack, out_valid, pix_i, pix_z
    );

    modport slave (
        input  reg_wr, reg_addr, gpu_din, gourd, gourz, daddmode, out_ready,
        output step_ack, out_valid, pix_i, pix_z
    );
endinterface

// File: rtl/dshade_iter.sv
// Gouraud intensity and Z iterator: four-lane accumulators stepped by signed
// phrase increments. Define DSHADE_SAT_EN to build the saturating add modes.
module dshade_iter #(
    parameter int IW = 24,
    parameter int ZW = 32
) (
    input  logic         sys_clk,
    input  logic         resetl,
    dshade_iter_if.slave bus
);
    localparam int LANES = 4;

    logic [IW-1:0] acc_i  [LANES];
    logic [ZW-1:0] acc_z  [LANES];
    logic [IW-1:0] next_i [LANES];
    logic [ZW-1:0] next_z [LANES];
    logic [IW-1:0] iinc;
    logic [ZW-1:0] zinc;
    logic [31:0]   phrase_i;
    logic [63:0]   phrase_z;
    logic          accept;

`ifdef DSHADE_SAT_EN
    logic sat_i;
    logic sat_z;

    // Bit IW of the widened sum is set exactly when the true result left the
    // unsigned range: carry for a positive step, borrow for a negative one.
    function automatic logic [IW-1:0] add_i(input logic [IW-1:0] a,
                                            input logic [IW-1:0] inc,
                                            input logic sat);
        logic [IW:0] s;
        s = {1'b0, a} + {inc[IW-1], inc};
        if (sat && s[IW]) return inc[IW-1] ? '0 : '1;
        return s[IW-1:0];
    endfunction

    function automatic logic [ZW-1:0] add_z(input logic [ZW-1:0] a,
                                            input logic [ZW-1:0] inc,
                                            input logic sat);
        logic [ZW:0] s;
        s = {1'b0, a} + {inc[ZW-1], inc};
        if (sat && s[ZW]) return inc[ZW-1] ? '0 : '1;
        return s[ZW-1:0];
    endfunction

    assign sat_i = (bus.daddmode == 3'd1) || (bus.daddmode == 3'd3);
    assign sat_z = (bus.daddmode == 3'd2) || (bus.daddmode == 3'd3);
`else
    logic unused_daddmode;
    assign unused_daddmode = ^bus.daddmode;
`endif

    assign accept       = resetl & (bus.gourd | bus.gourz) & (~bus.out_valid | bus.out_ready);
    assign bus.step_ack = accept;

    always_comb begin
        phrase_i = '0;
        phrase_z = '0;
        for (int n = 0; n < LANES; n++) begin
`ifdef DSHADE_SAT_EN
            next_i[n] = add_i(acc_i[n], iinc, sat_i);
            next_z[n] = add_z(acc_z[n], zinc, sat_z);
`else
            next_i[n] = acc_i[n] + iinc;
            next_z[n] = acc_z[n] + zinc;
`endif
            phrase_i[8*n +: 8]   = acc_i[n][IW-1 -: 8];
            phrase_z[16*n +: 16] = acc_z[n][ZW-1 -: 16];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            for (int n = 0; n < LANES; n++) begin
                acc_i[n] <= '0;
                acc_z[n] <= '0;
            end
            iinc          <= '0;
            zinc          <= '0;
            bus.out_valid <= 1'b0;
            bus.pix_i     <= '0;
            bus.pix_z     <= '0;
        end else begin
            // The phrase always reflects pre-add, pre-write accumulator values.
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.pix_i     <= phrase_i;
                bus.pix_z     <= phrase_z;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            // A GPU write to a lane overrides that lane's step add.
            for (int n = 0; n < LANES; n++) begin
                if (bus.reg_wr && bus.reg_addr == 4'(n))
                    acc_i[n] <= bus.gpu_din[IW-1:0];
                else if (accept && bus.gourd)
                    acc_i[n] <= next_i[n];

                if (bus.reg_wr && bus.reg_addr == 4'(8 + n))
                    acc_z[n] <= bus.gpu_din[ZW-1:0];
                else if (accept && bus.gourz)
                    acc_z[n] <= next_z[n];
            end

            if (bus.reg_wr && bus.reg_addr == 4'd4)  iinc <= bus.gpu_din[IW-1:0];
            if (bus.reg_wr && bus.reg_addr == 4'd12) zinc <= bus.gpu_din[ZW-1:0];
        end
    end
endmodule

// File: tb/tb_dshade_iter.sv
// Directed bench for dshade_iter: stimulus pushes hand-computed phrases into
// a queue, a posedge monitor pops and compares on every output transfer.
module tb_dshade_iter;
    logic sys_clk = 1'b0;
    logic resetl  = 1'b0;

    always #5 sys_clk = ~sys_clk;

`ifdef DSHADE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    dshade_iter_if bus();

    dshade_iter dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .bus     (bus.slave)
    );

    logic [95:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [63:0] z, input logic [31:0] i);
        exp_q.push_back({z, i});
    endtask

    // Monitor: one compare per phrase transfer.
    always @(posedge sys_clk) begin
        if (resetl && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL phrase: got %h expected none", {bus.pix_z, bus.pix_i});
            end else begin
                check("phrase", {bus.pix_z, bus.pix_i}, exp_q.pop_front());
            end
        end
    end

    // Drive one cycle's inputs at the falling edge; optionally check step_ack.
    task automatic cyc(input logic wr, input logic [3:0] addr, input logic [31:0] din,
                       input logic gd, input logic gz, input logic rdy, input int ack_exp);
        bus.reg_wr    = wr;
        bus.reg_addr  = addr;
        bus.gpu_din   = din;
        bus.gourd     = gd;
        bus.gourz     = gz;
        bus.out_ready = rdy;
        #1;
        if (ack_exp >= 0) check("step_ack", 96'(bus.step_ack), 96'(ack_exp));
        @(negedge sys_clk);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] din);
        cyc(1'b1, addr, din, 1'b0, 1'b0, 1'b1, -1);
    endtask

    task automatic step(input logic gd, input logic gz);
        cyc(1'b0, 4'd0, 32'd0, gd, gz, 1'b1, 1);
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, -1);
    endtask

    initial begin
        bus.reg_wr    = 1'b0;
        bus.reg_addr  = '0;
        bus.gpu_din   = '0;
        bus.gourd     = 1'b0;
        bus.gourz     = 1'b0;
        bus.daddmode  = 3'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge sys_clk);
        resetl = 1'b1;

        // Reset clears a freshly written lane and suppresses acks.
        wr(4'd0, 32'h0012_3456);
        resetl = 1'b0;
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 0);
        resetl = 1'b1;
        check("rst_out_valid", 96'(bus.out_valid), 96'd0);
        check("rst_pix_i", 96'(bus.pix_i), 96'd0);
        check("rst_pix_z", 96'(bus.pix_z), 96'd0);
        push(64'h0, 32'h0);
        step(1'b1, 1'b0);
        check("valid_after_step", 96'(bus.out_valid), 96'd1);
        idle();
        check("valid_drained", 96'(bus.out_valid), 96'd0);

        // Intensity stepping, back-to-back.
        wr(4'd0, 32'h0010_0000);
        wr(4'd1, 32'h0020_0000);
        wr(4'd2, 32'h0030_0000);
        wr(4'd3, 32'h0040_0000);
        wr(4'd4, 32'h0001_0000);
        push(64'h0, 32'h4030_2010);
        step(1'b1, 1'b0);
        check("valid_first", 96'(bus.out_valid), 96'd1);
        push(64'h0, 32'h4131_2111);
        step(1'b1, 1'b0);
        idle();

        // Negative Z increment: clamp to 0 in saturate mode, wrap otherwise.
        bus.daddmode = 3'd2;
        wr(4'd8,  32'h0001_0000);
        wr(4'd12, 32'hFFFE_0000);
        push(64'h0000_0000_0000_0001, 32'h4232_2212);
        step(1'b0, 1'b1);
        push(SAT ? 64'h0 : 64'hFFFE_FFFE_FFFE_FFFF, 32'h4232_2212);
        step(1'b0, 1'b1);
        idle();
        for (int n = 8; n < 13; n++) wr(4'(n), 32'h0);

        // Intensity overflow: clamp in saturate mode.
        bus.daddmode = 3'd1;
        wr(4'd0, 32'h00FF_8000);
        push(64'h0, 32'h4232_22FF);
        step(1'b1, 1'b0);
        push(64'h0, SAT ? 32'h4333_23FF : 32'h4333_2300);
        step(1'b1, 1'b0);
        idle();

        // Same overflow in wrap mode.
        bus.daddmode = 3'd0;
        wr(4'd0, 32'h00FF_8000);
        push(64'h0, 32'h4434_24FF);
        step(1'b1, 1'b0);
        push(64'h0, 32'h4535_2500);
        step(1'b1, 1'b0);
        idle();

        // Backpressure: held phrase, no acks, accumulators frozen.
        push(64'h0, 32'h4636_2601);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 0);
            check("stall_pix_i", 96'(bus.pix_i), 96'h4636_2601);
            check("stall_valid", 96'(bus.out_valid), 96'd1);
        end
        push(64'h0, 32'h4737_2702);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        idle();

        // Lane write during a step overrides only that lane.
        push(64'h0, 32'h4838_2803);
        cyc(1'b1, 4'd2, 32'h0005_0000, 1'b1, 1'b0, 1'b1, 1);
        push(64'h0, 32'h4905_2904);
        step(1'b1, 1'b0);

        // IINC write during a step: that step still uses the old increment.
        push(64'h0, 32'h4A06_2A05);
        cyc(1'b1, 4'd4, 32'h0002_0000, 1'b1, 1'b0, 1'b1, 1);
        push(64'h0, 32'h4B07_2B06);
        step(1'b1, 1'b0);
        push(64'h0, 32'h4D09_2D08);
        step(1'b1, 1'b0);
        idle();

        // Both requests together update both accumulator sets.
        wr(4'd12, 32'h0001_0000);
        push(64'h0, 32'h4F0B_2F0A);
        step(1'b1, 1'b1);
        push(64'h0001_0001_0001_0001, 32'h510D_310C);
        step(1'b1, 1'b0);
        idle();

        // Reset during a step request discards it.
        resetl = 1'b0;
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 1'b1, 0);
        resetl = 1'b1;
        check("rst2_out_valid", 96'(bus.out_valid), 96'd0);
        check("rst2_pix_i", 96'(bus.pix_i), 96'd0);
        push(64'h0, 32'h0);
        step(1'b1, 1'b1);
        idle();
        repeat (3) idle();

        check("queue_empty", 96'(exp_q.size()), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
